// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a registered 4:1 mux onto one shared
// output channel with a valid/ready handshake and a transfer counter.
module rr_mux_arbiter #(
    parameter int SIZE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [SIZE-1:0] d0,
    input  logic [SIZE-1:0] d1,
    input  logic [SIZE-1:0] d2,
    input  logic [SIZE-1:0] d3,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic [3:0]      grant,
    output logic [1:0]      sel,
    output logic [3:0]      ack,
    output logic [7:0]      count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n;
    logic [1:0]      sel_n;
    logic [3:0]      grant_n;
    logic [SIZE-1:0] data_n;
    logic            valid_n;
    logic [7:0]      count_n;
    logic [3:0]      masked;
    logic [1:0]      w;

    function automatic logic [SIZE-1:0] mux2(
        input logic            s,
        input logic [SIZE-1:0] a,
        input logic [SIZE-1:0] b
    );
        mux2 = s ? b : a;
    endfunction

    // Two-level tree: sel[0] picks within each pair, sel[1] picks the pair.
    function automatic logic [SIZE-1:0] mux4(
        input logic [1:0]      s,
        input logic [SIZE-1:0] a0,
        input logic [SIZE-1:0] a1,
        input logic [SIZE-1:0] a2,
        input logic [SIZE-1:0] a3
    );
        mux4 = mux2(s[1], mux2(s[0], a0, a1), mux2(s[0], a2, a3));
    endfunction

    // First requester at or after p, wrapping; scanned from the far end so
    // the nearest one wins.
    function automatic logic [1:0] pick(
        input logic [1:0] p,
        input logic [3:0] r
    );
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign ack = grant & {4{out_ready}};

    // The word just transferred may not win the same-edge re-arbitration.
    assign masked = req & ~(4'b0001 << sel);

    // State, pointer, grant and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            sel       <= 2'd0;
            grant     <= 4'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            count     <= 8'd0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            sel       <= sel_n;
            grant     <= grant_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            count     <= count_n;
        end
    end

    // Next-state: arbitrate from IDLE, hold under backpressure,
    // re-arbitrate back-to-back when a transfer completes.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        grant_n = grant;
        data_n  = out_data;
        valid_n = out_valid;
        count_n = count;
        w       = 2'd0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    w       = pick(ptr, req);
                    sel_n   = w;
                    grant_n = 4'b0001 << w;
                    data_n  = mux4(w, d0, d1, d2, d3);
                    valid_n = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    count_n = count + 8'd1;
                    ptr_n   = sel + 2'd1;
                    if (|masked) begin
                        w       = pick(sel + 2'd1, masked);
                        sel_n   = w;
                        grant_n = 4'b0001 << w;
                        data_n  = mux4(w, d0, d1, d2, d3);
                        valid_n = 1'b1;
                    end else begin
                        grant_n = 4'd0;
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scenario-task bench for rr_mux_arbiter with a transfer scoreboard.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] d0, d1, d2, d3;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] ack;
    logic [7:0] count;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] d;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    bit   sb_on;
    logic [7:0] exp_cnt;

    rr_mux_arbiter #(.SIZE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .grant     (grant),
        .sel       (sel),
        .ack       (ack),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: each handshake seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (sb_on && rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: got grant=%b data=%b, none expected",
                         grant, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (grant !== e.g || out_data !== e.d) begin
                    bad++;
                    $display("FAIL sb_xfer: got grant=%b data=%b want grant=%b data=%b",
                             grant, out_data, e.g, e.d);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        sb_on = 1'b0;
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        d0 = 2'd1; d1 = 2'd2; d2 = 2'd3; d3 = 2'd1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (grant !== 4'd0 || out_valid !== 1'b0 || out_data !== 2'd0 ||
                count !== 8'd0 || sel !== 2'd0) begin
                bad++;
                $display("FAIL reset_hold: got g=%b v=%b d=%b c=%0d s=%0d want all 0",
                         grant, out_valid, out_data, count, sel);
            end
        end
    endtask

    task automatic test_reset_mid;
        req = 4'b0010;
        out_ready = 1'b0;
        rst_n = 1'b1;
        tick;
        total++;
        if (grant !== 4'b0010 || out_valid !== 1'b1 || out_data !== 2'd2) begin
            bad++;
            $display("FAIL reset_mid_busy: got g=%b v=%b d=%b want 0010 1 10",
                     grant, out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 4'd0 || out_valid !== 1'b0 || out_data !== 2'd0 ||
            count !== 8'd0 || sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_async: got g=%b v=%b d=%b c=%0d s=%0d want all 0",
                     grant, out_valid, out_data, count, sel);
        end
        out_ready = 1'b1;
        tick;
        total++;
        if (grant !== 4'd0 || out_valid !== 1'b0 || count !== 8'd0) begin
            bad++;
            $display("FAIL reset_stay: got g=%b v=%b c=%0d want 0 0 0",
                     grant, out_valid, count);
        end
        req = 4'b0000;
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        sb_on = 1'b1;
    endtask

    task automatic test_single;
        req = 4'b0100;
        d2 = 2'b11;
        out_ready = 1'b1;
        push(4'b0100, 2'b11);
        tick;
        total++;
        if (grant !== 4'b0100 || sel !== 2'd2 || out_data !== 2'b11 ||
            out_valid !== 1'b1 || ack !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant: got g=%b s=%0d d=%b v=%b a=%b want 0100 2 11 1 0100",
                     grant, sel, out_data, out_valid, ack);
        end
        req = 4'b0000;
        tick;
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if (out_valid !== 1'b0 || count !== exp_cnt || grant !== 4'd0 || sel !== 2'd2) begin
            bad++;
            $display("FAIL single_done: got v=%b c=%0d g=%b s=%0d want 0 %0d 0000 2",
                     out_valid, count, grant, sel, exp_cnt);
        end
    endtask

    task automatic test_full;
        logic [1:0] ix;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        req = 4'b1111;
        d0 = 2'd0; d1 = 2'd1; d2 = 2'd2; d3 = 2'd3;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ix = 2'(k % 4);
            push(4'b0001 << ix, ix);
        end
        for (int k = 0; k < 5; k++) begin
            ix = 2'(k % 4);
            tick;
            total++;
            if (grant !== (4'b0001 << ix) || out_data !== ix || count !== 8'(k)) begin
                bad++;
                $display("FAIL full_step%0d: got g=%b d=%0d c=%0d want %b %0d %0d",
                         k, grant, out_data, count, 4'b0001 << ix, ix, k);
            end
        end
        req = 4'b0000;
        tick;
        exp_cnt = 8'd5;
        total++;
        if (out_valid !== 1'b0 || count !== exp_cnt) begin
            bad++;
            $display("FAIL full_end: got v=%b c=%0d want 0 %0d", out_valid, count, exp_cnt);
        end
    endtask

    task automatic test_backpressure;
        req = 4'b0010;
        d1 = 2'b01;
        out_ready = 1'b0;
        push(4'b0010, 2'b01);
        tick;
        d1 = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (out_data !== 2'b01 || out_valid !== 1'b1 || grant !== 4'b0010 ||
                count !== exp_cnt || ack !== 4'd0) begin
                bad++;
                $display("FAIL bp_hold%0d: got d=%b v=%b g=%b c=%0d a=%b want 01 1 0010 %0d 0000",
                         i, out_data, out_valid, grant, count, ack, exp_cnt);
            end
        end
        out_ready = 1'b1;
        req = 4'b0000;
        tick;
        exp_cnt = exp_cnt + 8'd1;
        total++;
        if (count !== exp_cnt || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got c=%0d v=%b want %0d 0", count, out_valid, exp_cnt);
        end
    endtask

    task automatic test_ptr_wrap;
        req = 4'b1000;
        d3 = 2'b11;
        d0 = 2'b00;
        out_ready = 1'b1;
        push(4'b1000, 2'b11);
        tick;
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_g3: got g=%b want 1000", grant);
        end
        req = 4'b1001;
        push(4'b0001, 2'b00);
        push(4'b1000, 2'b11);
        tick;
        total++;
        if (grant !== 4'b0001 || sel !== 2'd0) begin
            bad++;
            $display("FAIL wrap_g0: got g=%b s=%0d want 0001 0", grant, sel);
        end
        req = 4'b1000;
        tick;
        total++;
        if (grant !== 4'b1000 || sel !== 2'd3) begin
            bad++;
            $display("FAIL wrap_g3b: got g=%b s=%0d want 1000 3", grant, sel);
        end
        req = 4'b0000;
        tick;
        exp_cnt = exp_cnt + 8'd3;
        total++;
        if (count !== exp_cnt || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL wrap_end: got c=%0d v=%b want %0d 0", count, out_valid, exp_cnt);
        end
    endtask

    task automatic test_count_wrap;
        logic [1:0] ix;
        logic [1:0] nx;
        bit         saw_wrap;
        saw_wrap = 1'b0;
        req = 4'b1111;
        d0 = 2'd0; d1 = 2'd1; d2 = 2'd2; d3 = 2'd3;
        out_ready = 1'b1;
        push(4'b0001, 2'd0);
        tick;
        for (int n = 0; n < 256; n++) begin
            ix = 2'(n % 4);
            nx = 2'((n + 1) % 4);
            total++;
            if (grant !== (4'b0001 << ix) || count !== exp_cnt) begin
                bad++;
                $display("FAIL cwrap_step%0d: got g=%b c=%0d want %b %0d",
                         n, grant, count, 4'b0001 << ix, exp_cnt);
            end
            if (exp_cnt == 8'd255) begin
                tick;
                exp_cnt = exp_cnt + 8'd1;
                total++;
                if (count !== 8'd0) begin
                    bad++;
                    $display("FAIL cwrap_zero: got c=%0d want 0", count);
                end else begin
                    saw_wrap = 1'b1;
                end
                if (n == 255) req = 4'b0000;
                else push(4'b0001 << nx, nx);
                continue;
            end
            if (n == 255) req = 4'b0000;
            else push(4'b0001 << nx, nx);
            tick;
            exp_cnt = exp_cnt + 8'd1;
        end
        total++;
        if (!saw_wrap) begin
            bad++;
            $display("FAIL cwrap_seen: got no 255->0 wrap want one");
        end
        if (req != 4'b0000) begin
            req = 4'b0000;
            tick;
        end
        tick;
        total++;
        if (out_valid !== 1'b0 || count !== exp_cnt) begin
            bad++;
            $display("FAIL cwrap_end: got v=%b c=%0d want 0 %0d", out_valid, count, exp_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_cnt = 8'd0;
        test_reset;
        test_reset_mid;
        test_single;
        test_full;
        test_backpressure;
        test_ptr_wrap;
        test_count_wrap;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one SIZE-bit output channel between four requesters. It drives the select of a registered 4:1 mux built on the same selection semantics as yMux2/yMux4to1, and presents the winner's data downstream with a valid/ready handshake. It sits between the lab datapath producers and a single shared consumer, for example a register-file write port or an output latch, and counts completed transfers.

## Interface
- SIZE, 2, data width of each requester and of the output.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit i means requester i has data on d_i.
- d0, d1, d2, d3  input  SIZE  requester data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data holds a granted word.
- out_data  output  SIZE  registered mux output.
- grant  output  4  one-hot current grant; 0 when idle.
- sel  output  2  index of current or last grant; this is the mux select.
- ack  output  4  combinational, equal to grant & {4{out_ready}}; the requester's transfer completes at this edge.
- count  output  8  completed-transfer counter.

## Operation
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Internal state:
  - FSM with states IDLE and BUSY.
  - Round-robin pointer ptr, 2 bits.
- Arbitration function pick(p): the first i in the order p, p+1, p+2, p+3 (mod 4) with req[i]=1.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, with w=pick(ptr): sel<=w, grant<=onehot(w), out_data<=d_w, out_valid<=1, go to BUSY.
- BUSY while out_ready=0: hold out_valid, out_data, grant and sel. Changes on d_x or req have no effect.
- BUSY with out_ready=1 (transfer completes at this edge):
  - count<=count+1, wrapping 255 to 0.
  - ptr<=sel+1 mod 4.
  - Requests seen for the re-arbitration are req with bit sel masked off.
  - If any masked request remains, re-arbitrate the same edge with w=pick(sel+1). Load sel, grant, out_data and keep out_valid=1 (back-to-back), and stay in BUSY.
  - Otherwise clear out_valid and grant, keep sel, and go to IDLE.
- Requester rules:
  - Data is captured at grant. The requester need not hold d_i after the grant edge.
  - The requester deasserts req[i] in the cycle after ack[i].
  - If req[i] drops while granted, the latched transfer still completes.
- Fairness: a continuously requesting input waits at most 3 transfers between grants.
- Reset values, all applied immediately on rst_n low and independent of clk:
  - State IDLE, ptr=0, sel=0.
  - grant=0, out_valid=0, out_data=0, count=0.
  - Any in-flight transfer is discarded and not counted.

## Timing
- Latency from request to valid: req rises before edge N in IDLE, and out_valid/grant/out_data are valid after edge N (1 cycle).
- Throughput: 1 transfer per cycle when out_ready is held at 1 and requests are pending.
- ack is combinational from out_ready. A transfer happens at every edge where out_valid=1 and out_ready=1, and only then.
- out_ready asserted while out_valid=0 has no effect and does not increment count.
- Reset release: the first edge with rst_n=1 is a normal IDLE evaluation.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 with req=4'b1111 and out_ready=1, toggling clk. Then drop rst_n mid-BUSY without a clock edge.
  - Required: grant=0, out_valid=0, out_data=0, count=0, sel=0 immediately, and they stay there.
- Single requester:
  - Stimulus: from reset, req=4'b0100, d2=2'b11, out_ready=1.
  - Required: after the next edge, grant=4'b0100, sel=2, out_data=2'b11, out_valid=1, ack=4'b0100. After the following edge (req dropped), out_valid=0, count=1.
- Full contention:
  - Stimulus: req=4'b1111, d0..d3=0,1,2,3, out_ready=1 continuously.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with out_data 0, 1, 2, 3, 0 and count incrementing each cycle.
- Backpressure:
  - Stimulus: grant to requester 1 with d1=2'b01, then out_ready=0 for 3 cycles while d1 changes to 2'b10.
  - Required: out_data stays 2'b01, and out_valid and grant stay stable, with count unchanged. Then out_ready=1 gives a single count increment.
- Pointer wrap:
  - Stimulus: after a grant to requester 3 completes, req=4'b1001.
  - Required: requester 0 is granted next, then requester 3.
- Counter wrap:
  - Stimulus: perform 256 transfers.
  - Required: count reads 255 and then 0, with no other effect on operation.
